// File: rtl/data_buffer_ctrl.sv
// 64-byte endpoint FIFO on one single-ported storage array, shared by the CPU register block and the USB RX/TX engines.
// USB requests always win the array; a CPU request that loses is parked in a one-entry pending slot.
//
// state | meaning
// IDLE  | no CPU request outstanding; an uncontested CPU request executes at once
// PEND  | CPU request parked (cpu_wait=1); executes on the first cycle with no USB request
module data_buffer_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OCC_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  output logic [7:0]       rx_data,
  output logic             rx_data_valid,
  output logic             cpu_wait,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             empty,
  output logic             full,
  output logic             overflow_err,
  output logic             underflow_err
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              pend_pop, pend_pop_nxt;
  logic [7:0]        pend_byte, pend_byte_nxt;
  logic              req_push, req_pop, pop_cpu;
  logic [7:0]        push_byte;
  logic              usb_req, cpu_req;

  assign usb_req  = store_rx_packet_data | get_tx_packet_data;
  assign cpu_req  = store_tx_data | get_rx_data;
  assign cpu_wait = (state == PEND);
  assign empty    = (buffer_occupancy == '0);
  assign full     = (buffer_occupancy == OCC_W'(DEPTH));

  // Select the single array access for this cycle: clear, then USB push, USB pop, parked CPU op, fresh CPU op.
  always_comb begin
    state_nxt     = state;
    pend_pop_nxt  = pend_pop;
    pend_byte_nxt = pend_byte;
    req_push      = 1'b0;
    req_pop       = 1'b0;
    pop_cpu       = 1'b0;
    push_byte     = 8'h00;
    if (clear) begin
      state_nxt = IDLE;
    end else if (store_rx_packet_data) begin
      req_push  = 1'b1;
      push_byte = rx_packet_data;
    end else if (get_tx_packet_data) begin
      req_pop = 1'b1;
    end else if (state == PEND) begin
      state_nxt = IDLE;
      if (pend_pop) begin
        req_pop = 1'b1;
        pop_cpu = 1'b1;
      end else begin
        req_push  = 1'b1;
        push_byte = pend_byte;
      end
    end else if (cpu_req) begin
      if (store_tx_data) begin
        req_push  = 1'b1;
        push_byte = tx_data;
      end else begin
        req_pop = 1'b1;
        pop_cpu = 1'b1;
      end
    end
    if (!clear && state == IDLE && cpu_req && usb_req) begin
      state_nxt     = PEND;
      pend_pop_nxt  = !store_tx_data;
      pend_byte_nxt = tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pend_pop         <= 1'b0;
      pend_byte        <= 8'h00;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      buffer_occupancy <= '0;
      rx_data          <= 8'h00;
      rx_data_valid    <= 1'b0;
      tx_packet_data   <= 8'h00;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
    end else begin
      state         <= state_nxt;
      pend_pop      <= pend_pop_nxt;
      pend_byte     <= pend_byte_nxt;
      rx_data_valid <= 1'b0;
      if (clear) begin
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        buffer_occupancy <= '0;
        overflow_err     <= 1'b0;
        underflow_err    <= 1'b0;
      end else if (req_push) begin
        if (full) begin
          overflow_err <= 1'b1;
        end else begin
          wr_ptr           <= wr_ptr + ADDR_W'(1);
          buffer_occupancy <= buffer_occupancy + OCC_W'(1);
        end
      end else if (req_pop) begin
        rx_data_valid <= pop_cpu;
        if (empty) begin
          underflow_err <= 1'b1;
          if (pop_cpu) rx_data <= 8'h00;
          else         tx_packet_data <= 8'h00;
        end else begin
          rd_ptr           <= rd_ptr + ADDR_W'(1);
          buffer_occupancy <= buffer_occupancy - OCC_W'(1);
          if (pop_cpu) rx_data <= mem[rd_ptr];
          else         tx_packet_data <= mem[rd_ptr];
        end
      end
    end
  end

  // Storage has no reset; req_push is already suppressed by clear.
  always_ff @(posedge clk) begin
    if (req_push && !full) mem[wr_ptr] <= push_byte;
  end

endmodule

// File: tb/tb_data_buffer_ctrl.sv
// Bench for data_buffer_ctrl: single-cycle vector table, then hand-built arbitration, wrap, clear and reset sequences.
// Popped bytes are predicted into queues at issue time and compared when the DUT presents them.
module tb_data_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       get_rx_data = 1'b0;
  logic       store_rx_packet_data = 1'b0;
  logic [7:0] rx_packet_data = 8'h00;
  logic       get_tx_packet_data = 1'b0;
  logic [7:0] rx_data, tx_packet_data;
  logic       rx_data_valid, cpu_wait, empty, full, overflow_err, underflow_err;
  logic [6:0] buffer_occupancy;

  data_buffer_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear),
    .store_tx_data(store_tx_data), .tx_data(tx_data),
    .get_rx_data(get_rx_data), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .cpu_wait(cpu_wait),
    .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
    .get_tx_packet_data(get_tx_packet_data), .tx_packet_data(tx_packet_data),
    .buffer_occupancy(buffer_occupancy), .empty(empty), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] model[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic       tx_chk;

  typedef struct {
    logic       clr, srx, gtx, stx, grx;
    logic [7:0] din;
    logic [6:0] occ;
    logic       emp, ful, ovf, unf, rxv;
  } vec_t;
  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic status(input string tag, input int occ, input logic emp, input logic ful,
                        input logic ovf, input logic unf, input logic wt);
    check({tag, ".occ"}, 32'(buffer_occupancy), 32'(occ));
    check({tag, ".empty"}, 32'(empty), 32'(emp));
    check({tag, ".full"}, 32'(full), 32'(ful));
    check({tag, ".ovf"}, 32'(overflow_err), 32'(ovf));
    check({tag, ".unf"}, 32'(underflow_err), 32'(unf));
    check({tag, ".cpu_wait"}, 32'(cpu_wait), 32'(wt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear = 1'b0;
    store_tx_data = 1'b0;
    get_rx_data = 1'b0;
    store_rx_packet_data = 1'b0;
    get_tx_packet_data = 1'b0;
  endtask

  task automatic usb_push(input logic [7:0] b);
    store_rx_packet_data = 1'b1;
    rx_packet_data = b;
    if (model.size() < 64) model.push_back(b);
    step();
  endtask

  task automatic usb_pop();
    get_tx_packet_data = 1'b1;
    exp_tx.push_back(model.size() != 0 ? model.pop_front() : 8'h00);
    step();
  endtask

  // A USB pop that is not overridden by a push or clear updates tx_packet_data at its edge.
  always @(posedge clk or posedge rst) begin
    if (rst) tx_chk <= 1'b0;
    else     tx_chk <= get_tx_packet_data && !store_rx_packet_data && !clear;
  end

  always @(negedge clk) begin
    if (rx_data_valid) begin
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got strobe with data %0h, expected none", rx_data);
      end else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    if (tx_chk) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got pop data %0h, expected none", tx_packet_data);
      end else check("tx_packet_data", 32'(tx_packet_data), 32'(exp_tx.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    //           clr srx gtx stx grx din    occ  emp ful ovf unf rxv
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    status("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.rx_data", 32'(rx_data), 32'h0);
    check("reset.tx_data", 32'(tx_packet_data), 32'h0);
    check("reset.rxv", 32'(rx_data_valid), 32'h0);

    for (int i = 0; i < NV; i++) begin
      clear = vecs[i].clr;
      store_rx_packet_data = vecs[i].srx;
      rx_packet_data = vecs[i].din;
      get_tx_packet_data = vecs[i].gtx;
      store_tx_data = vecs[i].stx;
      tx_data = vecs[i].din;
      get_rx_data = vecs[i].grx;
      if (vecs[i].clr) model.delete();
      else if (vecs[i].srx || vecs[i].stx) model.push_back(vecs[i].din);
      else if (vecs[i].gtx) exp_tx.push_back(model.size() != 0 ? model.pop_front() : 8'h00);
      else if (vecs[i].grx) exp_rx.push_back(model.size() != 0 ? model.pop_front() : 8'h00);
      step();
      status($sformatf("vec%0d", i), int'(vecs[i].occ), vecs[i].emp, vecs[i].ful,
             vecs[i].ovf, vecs[i].unf, 1'b0);
      check($sformatf("vec%0d.rxv", i), 32'(rx_data_valid), 32'(vecs[i].rxv));
    end

    // CPU push collides with USB push: USB byte first, CPU byte one cycle later.
    store_tx_data = 1'b1; tx_data = 8'hA5;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h5A;
    model.push_back(8'h5A);
    model.push_back(8'hA5);
    step();
    status("colpush.pend", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    status("colpush.done", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    usb_pop();
    usb_pop();
    status("colpush.drain", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // CPU pop held off by three consecutive USB pushes.
    usb_push(8'h44);
    get_rx_data = 1'b1;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h90;
    exp_rx.push_back(model.pop_front());
    model.push_back(8'h90);
    step();
    check("colpop.wait1", 32'(cpu_wait), 32'h1);
    usb_push(8'h91);
    check("colpop.wait2", 32'(cpu_wait), 32'h1);
    usb_push(8'h92);
    check("colpop.wait3", 32'(cpu_wait), 32'h1);
    check("colpop.rxv_c4", 32'(rx_data_valid), 32'h0);
    step();
    check("colpop.wait_off", 32'(cpu_wait), 32'h0);
    check("colpop.rxv_c5", 32'(rx_data_valid), 32'h1);
    check("colpop.occ", 32'(buffer_occupancy), 32'd3);

    clear = 1'b1;
    model.delete();
    step();
    status("clear", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clear.rx_hold", 32'(rx_data), 32'h44);
    check("clear.rxv", 32'(rx_data_valid), 32'h0);

    // Fill, overflow, drain, underflow, then a push at the wrapped address.
    for (int i = 0; i < 64; i++) usb_push(8'(i));
    status("fill", 64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    usb_push(8'hFF);
    status("overflow", 64, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) usb_pop();
    status("drain", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    usb_pop();
    status("underflow", 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    usb_push(8'hC0);
    check("wrap.occ", 32'(buffer_occupancy), 32'd1);
    usb_pop();
    check("wrap.empty", 32'(empty), 32'h1);

    // Clear with occupancy 10, both flags set and a pending CPU push, alongside a USB push.
    for (int i = 1; i <= 9; i++) usb_push(8'(i));
    store_tx_data = 1'b1; tx_data = 8'hEE;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h0A;
    step();
    status("preclear", 10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear = 1'b1;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'hAA;
    model.delete();
    step();
    status("clear2", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("clear2.pend_dropped", 32'(buffer_occupancy), 32'd0);

    // Async reset while a CPU pop is parked with occupancy 5.
    for (int i = 1; i <= 4; i++) usb_push(8'(i));
    get_rx_data = 1'b1;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h05;
    step();
    status("prerst", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    status("midrst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst.rx_data", 32'(rx_data), 32'h0);
    check("midrst.tx_data", 32'(tx_packet_data), 32'h0);
    #3 rst = 1'b0;
    model.delete();
    step();
    step();
    check("postrst.rxv", 32'(rx_data_valid), 32'h0);
    status("postrst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
